// File: rtl/trace_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// trace_ctrl
// Trace capture controller sitting between the CPU instruction-load strobe
// and the instruction trace LIFO. Once armed it pushes every instruction
// until a PC-match or external trigger fires, then pushes a programmed
// number of post-trigger instructions and stops.
//
// Ports
//   clk, rst    system clock, asynchronous active-high reset
//   regsLOAD    CPU PC/IR load strobe (level, may be held)
//   cpuPC/HR    program counter and instruction register
//   trARM/STOP  CSL arm / stop requests (rising edge acts)
//   trMATCH     trigger PC compare value, trMASK selects compared bits
//   trPCEN      enable the PC-match trigger
//   trEXT       external trigger, sampled with the load strobe
//   trPOST      post-trigger instruction count, sampled at arm
//   trPUSH      single-cycle push strobe to the LIFO
//   trDIN       push data {PC, HR}
//   trCLR       single-cycle LIFO clear
//   trSTATE     0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   trTRIGPC    PC of the triggering instruction
//   trCOUNT     entries pushed since arm, saturating at buffer depth
// ---------------------------------------------------------------------------
module trace_ctrl #(
    parameter int PCW      = 18,
    parameter int POSTW    = 12,
    parameter int LOG2SIZE = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                regsLOAD,
    input  logic [PCW-1:0]      cpuPC,
    input  logic [35:0]         cpuHR,
    input  logic                trARM,
    input  logic                trSTOP,
    input  logic [PCW-1:0]      trMATCH,
    input  logic [PCW-1:0]      trMASK,
    input  logic                trPCEN,
    input  logic                trEXT,
    input  logic [POSTW-1:0]    trPOST,
    output logic                trPUSH,
    output logic [PCW+35:0]     trDIN,
    output logic                trCLR,
    output logic [1:0]          trSTATE,
    output logic [PCW-1:0]      trTRIGPC,
    output logic [LOG2SIZE:0]   trCOUNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LOG2SIZE:0] COUNT_MAX = {1'b1, {LOG2SIZE{1'b0}}};

    state_t               state_q, state_d;
    logic                 ld_prev_q, ld_prev_d;
    logic                 arm_prev_q, arm_prev_d;
    logic                 stop_prev_q, stop_prev_d;
    logic                 push_q, push_d;
    logic                 clr_q, clr_d;
    logic [PCW+35:0]      din_q, din_d;
    logic [PCW-1:0]       trigpc_q, trigpc_d;
    logic [POSTW-1:0]     post_q, post_d;
    logic [LOG2SIZE:0]    count_q, count_d;

    logic                 ld;
    logic                 arm;
    logic                 stop;
    logic                 trig_hit;

    // Rising-edge detects against the previous-cycle level of each strobe.
    assign ld   = regsLOAD & ~ld_prev_q;
    assign arm  = trARM & ~arm_prev_q;
    assign stop = trSTOP & ~stop_prev_q;

    // Masked PC compare: only bits with trMASK = 1 must match.
    assign trig_hit = trEXT | (trPCEN & (((cpuPC ^ trMATCH) & trMASK) == '0));

    always_comb begin
        state_d     = state_q;
        ld_prev_d   = regsLOAD;
        arm_prev_d  = trARM;
        stop_prev_d = trSTOP;
        push_d      = 1'b0;
        clr_d       = 1'b0;
        din_d       = din_q;
        trigpc_d    = trigpc_q;
        post_d      = post_q;
        count_d     = count_q;

        // Count follows the LIFO fill level, so it stops where the LIFO is full.
        if (push_q && (count_q != COUNT_MAX)) begin
            count_d = count_q + (LOG2SIZE+1)'(1);
        end

        // Stop beats arm beats load; an arm also swallows a coincident load,
        // which keeps trCLR and trPUSH from ever landing in the same cycle.
        if (stop) begin
            state_d = IDLE;
        end else if (arm) begin
            state_d = ARMED;
            clr_d   = 1'b1;
            count_d = '0;
            post_d  = trPOST;
        end else if (ld) begin
            case (state_q)
                ARMED: begin
                    push_d = 1'b1;
                    din_d  = {cpuPC, cpuHR};
                    if (trig_hit) begin
                        trigpc_d = cpuPC;
                        state_d  = (post_q == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    push_d = 1'b1;
                    din_d  = {cpuPC, cpuHR};
                    post_d = post_q - POSTW'(1);
                    if (post_q == POSTW'(1)) begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_prev_q   <= 1'b0;
            arm_prev_q  <= 1'b0;
            stop_prev_q <= 1'b0;
            push_q      <= 1'b0;
            clr_q       <= 1'b0;
            din_q       <= '0;
            trigpc_q    <= '0;
            post_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            ld_prev_q   <= ld_prev_d;
            arm_prev_q  <= arm_prev_d;
            stop_prev_q <= stop_prev_d;
            push_q      <= push_d;
            clr_q       <= clr_d;
            din_q       <= din_d;
            trigpc_q    <= trigpc_d;
            post_q      <= post_d;
            count_q     <= count_d;
        end
    end

    assign trPUSH   = push_q;
    assign trCLR    = clr_q;
    assign trDIN    = din_q;
    assign trSTATE  = state_q;
    assign trTRIGPC = trigpc_q;
    assign trCOUNT  = count_q;

endmodule

// File: doc/trace_ctrl.md
Name: trace_ctrl

Overview:
Trace capture controller between the CPU instruction-load strobe and the 4K-entry instruction trace LIFO. Software arms it over the CSL. It records instructions until a PC-match or external trigger fires, then records a programmed number of post-trigger instructions and stops. It generates the single-cycle push, the buffer clear and the 54-bit push data, and reports state, trigger PC and entry count back to the CSL.

Parameters:
PCW, 18, program counter width (cpuPC[18:35])
POSTW, 12, post-trigger counter width
LOG2SIZE, 12, log2 of trace buffer depth; entry counter saturates at 2**LOG2SIZE

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
regsLOAD  input  1  CPU PC/IR load strobe, level, may be held multiple cycles
cpuPC  input  18  program counter [18:35]
cpuHR  input  36  instruction register [0:35]
trARM  input  1  CSL arm request, level; rising edge acts
trSTOP  input  1  CSL stop request, level; rising edge acts
trMATCH  input  18  trigger PC compare value
trMASK  input  18  compare mask; 1 = bit compared
trPCEN  input  1  enable PC-match trigger
trEXT  input  1  external trigger, level, sampled on load pulse
trPOST  input  12  post-trigger instruction count
trPUSH  output  1  push strobe to LIFO, exactly 1 cycle
trDIN  output  54  push data {PC, HR}
trCLR  output  1  LIFO clear, exactly 1 cycle
trSTATE  output  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
trTRIGPC  output  18  PC of triggering instruction
trCOUNT  output  13  entries pushed since arm, saturating at 4096

Behaviour:
- Reset (async): state IDLE. trPUSH, trCLR, trDIN, trTRIGPC, trCOUNT, post counter and all edge-detect flops = 0.
- Edge detects are registered, following the same scheme for each strobe:
  - ld = regsLOAD & !d_regsLOAD
  - arm = trARM & !d_trARM
  - stop = trSTOP & !d_trSTOP
- A regsLOAD held N cycles produces one ld.
- Trigger is evaluated in ARMED only:
  - trig = ld & (trEXT | (trPCEN & (((cpuPC ^ trMATCH) & trMASK) == 0)))
  - trMASK = 0 with trPCEN = 1 triggers on the first ld.
- Priority each cycle: stop > arm > ld processing.
- IDLE: ld ignored; arm -> ARMED.
- Any state, arm (with no stop in the same cycle):
  - next state ARMED
  - trCLR = 1 next cycle
  - trCOUNT <= 0
  - post counter <= trPOST
  - trTRIGPC unchanged
  - a coincident ld is dropped.
- Any state, stop -> IDLE; a coincident ld is not pushed. Stop in IDLE has no effect.
- ARMED:
  - Every ld pushes.
  - On trig: push, trTRIGPC <= cpuPC, next state POST, or DONE if trPOST == 0.
- POST:
  - Every ld pushes and decrements the post counter.
  - The ld that takes the counter from 1 to 0 pushes and moves to DONE.
  - Exactly trPOST instructions are recorded after the trigger instruction.
  - trPOST is sampled only at arm.
- DONE: no pushes; holds until arm or stop.
- Push timing, registered with 1-cycle latency:
  - On a pushing ld in cycle T, trPUSH = 1 and trDIN = {cpuPC, cpuHR} captured at T, both in cycle T+1 only.
  - trDIN holds its value until the next push.
- trCOUNT increments on each trPUSH cycle and saturates at 4096, mirroring the LIFO full condition. It is never cleared except by arm or rst.
- trCLR and trPUSH are never asserted in the same cycle.
- Reset mid-operation: immediate return to IDLE, any pending push is discarded, the LIFO is not cleared (it is cleared on the next arm).

Test Plan:
- Reset, then arm, then 3 ld with trPCEN = 0, trEXT = 0 -> trCLR one pulse; 3 trPUSH pulses each 1 cycle after ld; trCOUNT = 3; trSTATE = 1.
- trMATCH = 0o001000, trMASK = 0o777777, trPOST = 2; ld PCs 0o777, 0o1000, 0o1001, 0o1002, 0o1003 -> 4 pushes; trTRIGPC = 0o1000; trSTATE = 3 after the ld at 0o1002; no push for 0o1003.
- trPOST = 0, trEXT = 1 on the first ld after arm -> 1 push, trSTATE goes directly 1 -> 3.
- regsLOAD held 5 cycles -> exactly one trPUSH. arm and stop rising in the same cycle -> trSTATE = 0, no trCLR.
- 4100 ld in ARMED with no trigger -> trCOUNT saturates at 4096; trPUSH continues each ld.
- rst asserted the cycle after a trigger ld -> trPUSH stays 0, trSTATE = 0 asynchronously, trTRIGPC = 0.
